decode_ctrl_pipe: RTL

Registered, handshaked control-decode stage for the 32-bit MIPS pipeline, placed between fetch/IF-ID and the execute stage. It decodes the full instruction word into the datapath control word and holds it in an output register under valid/ready flow control. It stalls decode for a parametrised number of cycles after a multicycle multiply, and supports flush for branch/exception recovery.

---
 rtl/decode_ctrl_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_pipe.sv
// Registered MIPS control-decode stage with valid/ready output, MULTU wait and flush.
// Optional illegal-instruction trap state is built when CU_ILLEGAL_TRAP_EN is defined.
module decode_ctrl_pipe #(
   parameter int MUL_LATENCY = 4,
   parameter int ALU_CTRL_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  RegWrite,
   output logic                  MemToReg,
   output logic                  MemWrite,
   output logic                  ALUSrcA,
   output logic                  RegDst,
   output logic [1:0]            ALUSrcB,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  busy,
   output logic                  illegal
);

   localparam int CNT_W = $clog2(MUL_LATENCY + 1);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MUL_WAIT = 2'd1;
`ifdef CU_ILLEGAL_TRAP_EN
   localparam logic [1:0] ST_TRAP     = 2'd2;
`endif

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src_a;
      logic       reg_dst;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       is_multu;
      logic       illegal;
   } ctrl_t;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   ctrl_t            r_word;

   ctrl_t            w_dec;
   logic             w_accept;
   logic             w_out_hs;
   logic             w_trap;
   logic             w_unused;

   // Register fields and shamt never affect the control word.
   assign w_unused = ^instr[25:6];

   // NOTE: every field gets a default first so no path through the case infers a latch.
   always_comb begin
      w_dec = '0;
      unique case (instr[31:26])
         6'b000000: begin
            w_dec.reg_write = 1'b1;
            w_dec.reg_dst   = 1'b1;
            case (instr[5:0])
               6'b100000: w_dec.alu_op = 4'b0100;
               6'b100100: w_dec.alu_op = 4'b1010;
               6'b011001: begin
                  w_dec.alu_op   = 4'b0110;
                  w_dec.is_multu = 1'b1;
               end
               6'b100101: w_dec.alu_op = 4'b1000;
               6'b100010: w_dec.alu_op = 4'b0101;
               6'b100110: w_dec.alu_op = 4'b1011;
               6'b000000, 6'b000011, 6'b000010: begin
                  w_dec.alu_src_a = 1'b1;
                  w_dec.alu_src_b = 2'b10;
                  w_dec.alu_op    = (instr[1:0] == 2'b00) ? 4'b1100 :
                                    (instr[1:0] == 2'b11) ? 4'b1110 : 4'b1101;
               end
               default: begin
                  w_dec         = '0;
                  w_dec.illegal = 1'b1;
               end
            endcase
         end
         6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b100011, 6'b101011: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src_b = 2'b01;
            case (instr[31:26])
               6'b001100: w_dec.alu_op = 4'b1010;
               6'b001101: w_dec.alu_op = 4'b1000;
               6'b001110: w_dec.alu_op = 4'b1011;
               default:   w_dec.alu_op = 4'b0100;
            endcase
            w_dec.mem_to_reg = (instr[31:26] == 6'b100011);
            if (instr[31:26] == 6'b101011) begin
               w_dec.mem_write = 1'b1;
               w_dec.reg_write = 1'b0;
            end
         end
         default: w_dec.illegal = 1'b1;
      endcase
   end

`ifdef CU_ILLEGAL_TRAP_EN
   assign w_trap = (r_state == ST_TRAP);
   // A held illegal word blocks new accepts so its handshake can enter TRAP cleanly.
   assign in_ready = rst_n & (r_state == ST_RUN) & (~r_out_valid | out_ready) & ~flush
                   & ~(r_out_valid & r_word.is_multu) & ~(r_out_valid & r_word.illegal);
`else
   assign w_trap = 1'b0;
   assign in_ready = rst_n & (r_state == ST_RUN) & (~r_out_valid | out_ready) & ~flush
                   & ~(r_out_valid & r_word.is_multu);
`endif

   assign w_accept = in_valid & in_ready;
   assign w_out_hs = r_out_valid & out_ready;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_word      <= '0;
      end else if (flush) begin
         r_state     <= ST_RUN;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_accept) begin
                  r_out_valid <= 1'b1;
                  r_word      <= w_dec;
               end else if (w_out_hs) begin
                  r_out_valid <= 1'b0;
               end
               if (w_out_hs && r_word.is_multu && (MUL_LATENCY > 1)) begin
                  r_state <= ST_MUL_WAIT;
                  r_cnt   <= CNT_W'(MUL_LATENCY - 1);
               end
`ifdef CU_ILLEGAL_TRAP_EN
               if (w_out_hs && r_word.illegal) r_state <= ST_TRAP;
`endif
            end
            ST_MUL_WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= ST_RUN;
            end
`ifdef CU_ILLEGAL_TRAP_EN
            ST_TRAP: r_state <= ST_TRAP;
`endif
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign out_valid  = r_out_valid;
   assign busy       = (r_state == ST_MUL_WAIT);
   assign RegWrite   = r_out_valid & r_word.reg_write;
   assign MemToReg   = r_out_valid & r_word.mem_to_reg;
   assign MemWrite   = r_out_valid & r_word.mem_write;
   assign ALUSrcA    = r_out_valid & r_word.alu_src_a;
   assign RegDst     = r_out_valid & r_word.reg_dst;
   assign ALUSrcB    = r_out_valid ? r_word.alu_src_b : 2'b00;
   assign ALUControl = r_out_valid ? ALU_CTRL_W'(r_word.alu_op) : '0;
   assign illegal    = (r_out_valid & r_word.illegal) | w_trap;

endmodule
